sha256_padder: RTL and testbench

Upstream feeder for the SHA-256 core. Accepts a message as a stream of big-endian 32-bit words and assembles 512-bit blocks. Applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit big-endian message bit length. Each block is presented to the core over a valid/ready handshake, and the final block of a message is flagged.

---
 rtl/sha256_pkg.sv | 23 ++
 rtl/sha256_pad_mask.sv | 31 +++
 rtl/sha256_padder.sv | 176 +++++++++++++++++
 tb/tb_sha256_padder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and the byte keep-mask helper for the SHA-256 message padder.
package sha256_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } sha_pad_state_e;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned LEN_OFFSET  = 56;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  // Bit i set when message byte i of the block (byte 0 = MSB) lies before pad position p.
  function automatic logic [BLOCK_BYTES-1:0] keep_mask(input logic [6:0] p);
    logic [BLOCK_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      m[i] = (7'(i) < p);
    end
    return m;
  endfunction

endpackage

// File: rtl/sha256_pad_mask.sv
// Combinational padding builder: clears bytes from p, inserts 0x80 at p and, when it fits,
// the 64-bit bit length in bytes 56..63.
module sha256_pad_mask
  import sha256_pkg::*;
(
  input  logic [511:0] blk_i,
  input  logic [6:0]   p_i,
  input  logic [63:0]  bit_len_i,
  output logic [511:0] blk_o,
  output logic         needs_extra_o
);

  logic [BLOCK_BYTES-1:0] keep;

  always_comb begin
    blk_o         = '0;
    keep          = keep_mask(p_i);
    needs_extra_o = (p_i > 7'(LEN_OFFSET - 1));
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (keep[i]) begin
        blk_o[8*(63-i) +: 8] = blk_i[8*(63-i) +: 8];
      end else if (7'(i) == p_i) begin
        blk_o[8*(63-i) +: 8] = PAD_BYTE;
      end
      if (!needs_extra_o && (i >= LEN_OFFSET)) begin
        blk_o[8*(63-i) +: 8] = bit_len_i[8*(63-i) +: 8];
      end
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks with FIPS 180-4 padding.
// Optional block counter output blk_cnt_o enabled by SHA256_PADDER_BLKCNT_EN.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned BlockWidth = 512,
  parameter int unsigned WordWidth  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WordWidth-1:0]  data_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [2:0]            bytes_i,
  output logic                  ready_o,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_valid_o,
  output logic                  block_last_o,
  input  logic                  block_ready_i,
  output logic [63:0]           msg_len_o
`ifdef SHA256_PADDER_BLKCNT_EN
  ,
  output logic [31:0]           blk_cnt_o
`endif
);

  localparam int unsigned CNT_W = 61;

  sha_pad_state_e state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [511:0]     block_q, block_d, blk_word, blk_pad, blk_extra;
  logic             valid_q, valid_d, last_q, last_d;
  logic             extra_q, extra_d, p64_q, p64_d;
  logic [63:0]      len_q, len_d, bit_len_inc, bit_len_cur;
  logic [2:0]       n;
  logic [6:0]       p;
  logic             needs_extra, in_xfer, out_xfer;

  // Bytes contributed by the current word; short counts only apply to a last word.
  always_comb begin
    n = 3'd4;
    if (last_i && (bytes_i < 3'd4)) begin
      n = bytes_i;
    end
  end

  assign p           = {1'b0, idx_q, 2'b00} + 7'(n);
  assign cnt_inc     = cnt_q + CNT_W'(n);
  assign bit_len_inc = {cnt_inc, 3'b000};
  assign bit_len_cur = {cnt_q, 3'b000};
  assign in_xfer     = valid_i && (state_q == COLLECT);
  assign out_xfer    = valid_q && block_ready_i;
  assign blk_extra   = {(p64_q ? PAD_BYTE : 8'h00), 440'b0, bit_len_cur};

  always_comb begin
    blk_word = block_q;
    for (int unsigned w = 0; w < 16; w++) begin
      if (idx_q == 4'(w)) begin
        blk_word[32*(15-w) +: 32] = data_i;
      end
    end
  end

  sha256_pad_mask u_pad_mask (
    .blk_i         (blk_word),
    .p_i           (p),
    .bit_len_i     (bit_len_inc),
    .blk_o         (blk_pad),
    .needs_extra_o (needs_extra)
  );

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    valid_d = valid_q;
    last_d  = last_q;
    extra_d = extra_q;
    p64_d   = p64_q;
    len_d   = len_q;
    unique case (state_q)
      COLLECT: begin
        if (in_xfer) begin
          cnt_d = cnt_inc;
          if (last_i) begin
            block_d = blk_pad;
            idx_d   = '0;
            last_d  = !needs_extra;
            extra_d = needs_extra;
            p64_d   = (p == 7'd64);
            if (!needs_extra) begin
              len_d = bit_len_inc;
            end
            valid_d = 1'b1;
            state_d = EMIT;
          end else begin
            block_d = blk_word;
            idx_d   = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              last_d  = 1'b0;
              valid_d = 1'b1;
              state_d = EMIT;
            end
          end
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (extra_q) begin
            block_d = blk_extra;
            last_d  = 1'b1;
            len_d   = bit_len_cur;
            extra_d = 1'b0;
          end else begin
            if (last_q) begin
              cnt_d = '0;
              idx_d = '0;
            end
            last_d  = 1'b0;
            valid_d = 1'b0;
            state_d = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      cnt_q   <= '0;
      block_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      p64_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      extra_q <= extra_d;
      p64_q   <= p64_d;
      len_q   <= len_d;
    end
  end

  assign ready_o       = (state_q == COLLECT);
  assign block_o       = block_q;
  assign block_valid_o = valid_q;
  assign block_last_o  = last_q;
  assign msg_len_o     = len_q;

`ifdef SHA256_PADDER_BLKCNT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_cnt_q <= '0;
    end else if (out_xfer) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign blk_cnt_o = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed and random messages against a byte-level
// FIPS 180-4 padding model. Define SHA256_PADDER_BLKCNT_EN to also check blk_cnt_o.
module tb_sha256_padder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  data_i;
  logic         valid_i;
  logic         last_i;
  logic [2:0]   bytes_i;
  logic         ready_o;
  logic [511:0] block_o;
  logic         block_valid_o;
  logic         block_last_o;
  logic         block_ready_i;
  logic [63:0]  msg_len_o;
`ifdef SHA256_PADDER_BLKCNT_EN
  logic [31:0]  blk_cnt_o;
`endif

  sha256_padder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .last_i        (last_i),
    .bytes_i       (bytes_i),
    .ready_o       (ready_o),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_last_o  (block_last_o),
    .block_ready_i (block_ready_i),
    .msg_len_o     (msg_len_o)
`ifdef SHA256_PADDER_BLKCNT_EN
    ,
    .blk_cnt_o     (blk_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int           n_cmp = 0;
  int           n_err = 0;
  int           exp_cnt = 0;
  int           force_stall = -1;
  logic [7:0]   msg[$];
  logic [511:0] exp_blk[$];
  logic         exp_last[$];
  logic [63:0]  exp_len;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic abort(input string tag);
    chk(tag, 512'(ready_o), 512'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "bench stopped");
  endtask

  // Reference: message bytes, 0x80, zeros to 56 mod 64, then 64-bit bit length; split in blocks.
  task automatic make_expected();
    logic [7:0]   pad[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nb;
    pad  = msg;
    bits = 64'(msg.size()) << 3;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int k = 7; k >= 0; k--) pad.push_back(bits[8*k +: 8]);
    nb = pad.size() / 64;
    exp_blk.delete();
    exp_last.delete();
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[8*(63-j) +: 8] = pad[64*b + j];
      exp_blk.push_back(blk);
      exp_last.push_back(b == nb - 1);
    end
    exp_len = bits;
  endtask

  // Check the presented block, stall it a while, then complete the transfer.
  task automatic service_block();
    logic [511:0] blk;
    logic         lst;
    int           stall;
    if (exp_blk.size() == 0) begin
      chk("unexpected_block", 512'(block_valid_o), 512'(0));
      blk = block_o;
      lst = block_last_o;
    end else begin
      blk = exp_blk.pop_front();
      lst = exp_last.pop_front();
    end
    chk("block", block_o, blk);
    chk("block_last", 512'(block_last_o), 512'(lst));
    if (lst) chk("msg_len", 512'(msg_len_o), 512'(exp_len));
    chk("ready_in_emit", 512'(ready_o), 512'(0));
    stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
    for (int s = 0; s < stall; s++) begin
      block_ready_i = 1'b0;
      if (force_stall >= 0) begin
        valid_i = 1'b1;
        last_i  = 1'b1;
        bytes_i = 3'd4;
        data_i  = $urandom;
      end
      step();
      chk("hold_block", block_o, blk);
      chk("hold_valid", 512'(block_valid_o), 512'(1));
      chk("hold_last", 512'(block_last_o), 512'(lst));
      chk("hold_ready", 512'(ready_o), 512'(0));
    end
    block_ready_i = 1'b1;
    step();
    block_ready_i = 1'b0;
    valid_i       = 1'b0;
    last_i        = 1'b0;
    exp_cnt++;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!ready_o) begin
      if (block_valid_o) service_block();
      else step();
      guard++;
      if (guard > 100) abort("ready_timeout");
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_blk.size() > 0) begin
      if (block_valid_o) service_block();
      else step();
      guard++;
      if (guard > 100) abort("drain_timeout");
    end
    chk("idle_ready", 512'(ready_o), 512'(1));
    chk("idle_valid", 512'(block_valid_o), 512'(0));
`ifdef SHA256_PADDER_BLKCNT_EN
    chk("blk_cnt", 512'(blk_cnt_o), 512'(exp_cnt));
`endif
  endtask

  // Feed the message in msg as words; zero_tail appends a bytes_i=0 last word when it fits.
  task automatic send_msg(input bit zero_tail);
    int         len, total, lastb, nb, widx;
    bit         is_last;
    logic [31:0] word;
    len = msg.size();
    make_expected();
    if (len == 0) begin
      total = 1;
      lastb = 0;
    end else begin
      total = (len + 3) / 4;
      lastb = len - 4 * (total - 1);
      if (zero_tail && lastb == 4) begin
        total++;
        lastb = 0;
      end
    end
    widx = 0;
    for (int w = 0; w < total; w++) begin
      is_last = (w == total - 1);
      nb      = is_last ? lastb : 4;
      word    = $urandom;
      for (int j = 0; j < nb; j++) word[8*(3-j) +: 8] = msg[4*w + j];
      repeat ($urandom_range(0, 1)) step();
      wait_ready();
      valid_i = 1'b1;
      data_i  = word;
      last_i  = is_last;
      if (!is_last)     bytes_i = 3'($urandom_range(0, 7));
      else if (nb == 4) bytes_i = 3'($urandom_range(4, 7));
      else              bytes_i = 3'(nb);
      step();
      valid_i = 1'b0;
      last_i  = 1'b0;
      if (is_last || widx == 15) chk("latency", 512'(block_valid_o), 512'(1));
      widx = (widx + 1) % 16;
    end
    drain();
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  task automatic abc_case();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
    make_expected();
    wait_ready();
    valid_i = 1'b1;
    data_i  = 32'h6162_6300;
    last_i  = 1'b1;
    bytes_i = 3'd3;
    step();
    valid_i = 1'b0;
    last_i  = 1'b0;
    chk("abc_latency", 512'(block_valid_o), 512'(1));
    chk("abc_word0", 512'(block_o[511:480]), 512'(32'h6162_6380));
    chk("abc_len_field", 512'(block_o[63:0]), 512'(64'h18));
    chk("abc_last", 512'(block_last_o), 512'(1));
    chk("abc_msg_len", 512'(msg_len_o), 512'(24));
    drain();
  endtask

  task automatic check_reset_state();
    chk("rst_valid", 512'(block_valid_o), 512'(0));
    chk("rst_last", 512'(block_last_o), 512'(0));
    chk("rst_msg_len", 512'(msg_len_o), 512'(0));
    chk("rst_block", block_o, 512'(0));
    chk("rst_ready", 512'(ready_o), 512'(1));
`ifdef SHA256_PADDER_BLKCNT_EN
    chk("rst_blk_cnt", 512'(blk_cnt_o), 512'(0));
`endif
  endtask

  initial begin
    rst_i         = 1'b1;
    data_i        = '0;
    valid_i       = 1'b0;
    last_i        = 1'b0;
    bytes_i       = '0;
    block_ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    check_reset_state();

    abc_case();

    rand_msg(0);
    send_msg(1'b0);
    rand_msg(56);
    send_msg(1'b0);
    rand_msg(64);
    send_msg(1'b0);
    rand_msg(120);
    send_msg(1'b0);
    rand_msg(8);
    send_msg(1'b1);

    force_stall = 5;
    rand_msg(10);
    send_msg(1'b0);
    force_stall = -1;

    for (int t = 0; t < 24; t++) begin
      rand_msg(int'($urandom_range(0, 150)));
      send_msg(1'($urandom_range(0, 1)));
    end

    // Abandon a message after 7 words, reset, then expect a clean "abc".
    rand_msg(100);
    for (int w = 0; w < 7; w++) begin
      wait_ready();
      valid_i = 1'b1;
      data_i  = {msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]};
      last_i  = 1'b0;
      bytes_i = 3'd4;
      step();
      valid_i = 1'b0;
    end
    rst_i = 1'b1;
    step();
    rst_i   = 1'b0;
    exp_cnt = 0;
    exp_blk.delete();
    exp_last.delete();
    check_reset_state();
    abc_case();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
